if_fetch_queue: RTL
===================

# if_fetch_queue

Parametrised instruction-fetch front end for the core_lapido pipeline. It replaces the single-entry IF stage with an N-deep prefetch queue. It issues word-addressed reads to the instruction memory and buffers {pc, instruction} pairs for the ID stage. On a branch or jump it flushes the queue and redirects fetch, and it holds its output while the hazard detection unit stalls the pipeline.

## Interface
Parameters:
- PC_WIDTH, 32, width of PC and memory address (word address, PC advances by 1)
- INST_WIDTH, 32, instruction width
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous reset, active-high
- branch_taken  in  1  redirect to branch_addr (from EX)
- branch_addr  in  PC_WIDTH  branch target
- is_jump  in  1  redirect to jump_addr (from ID)
- jump_addr  in  PC_WIDTH  jump target
- stall_pipeline  in  1  ID cannot accept; head entry must hold
- mem_req  out  1  read request this cycle
- mem_addr  out  PC_WIDTH  read address
- mem_rdata  in  INST_WIDTH  read data, valid exactly one cycle after mem_req
- out_valid  out  1  head entry present
- instruction  out  INST_WIDTH  head instruction
- pc  out  PC_WIDTH  head PC
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- State: fetch_pc, circular buffer (rd_ptr, wr_ptr, count), inflight flag, drop flag.
- Redirect: redirect = branch_taken | is_jump.
  - branch_taken has priority over is_jump.
  - target = branch_taken ? branch_addr : jump_addr.
- Issue: mem_req = redirect | (count + inflight < DEPTH).
  - mem_addr = redirect ? target : fetch_pc. Both are combinational.
  - On issue: fetch_pc ← mem_addr + 1, which wraps modulo 2^PC_WIDTH. inflight ← 1 and the issued address is recorded.
  - Otherwise inflight ← 0.
- Response:
  - When inflight is high and drop is low, {recorded addr, mem_rdata} is written at wr_ptr.
  - When drop is high, the response is discarded.
- Pop: when out_valid & !stall_pipeline, rd_ptr advances.
  - A push and a pop in the same cycle leave count unchanged.
- Redirect flush:
  - count, rd_ptr and wr_ptr ← 0 at the edge. Any pop or push in that cycle is cancelled.
  - drop ← 0, because the old in-flight response is discarded in the redirect cycle itself.
  - The target request issued in the same cycle is kept.
  - Redirect overrides stall_pipeline.
- Outputs:
  - instruction and pc come from buffer[rd_ptr] when count > 0.
  - When empty, both are 0 and out_valid = 0.
- Full: issue is gated by count + inflight < DEPTH, so a write never overflows. A pop in the same cycle does not open a slot until the next cycle.

## Timing
- Reset values:
  - fetch_pc = RESET_PC.
  - count, inflight, drop, pointers = 0.
  - out_valid, instruction, pc = 0.
  - mem_req is driven combinationally and is high in the first cycle after reset deasserts.
- Reset asserted mid-operation clears everything immediately (asynchronous). The in-flight response is ignored.
- Fetch latency: a request issued in cycle t is pushed at the end of t+1 and is visible on out_valid in t+2.
- Steady state with no stall: one instruction per cycle, with consecutive pc values.
- Redirect in cycle n:
  - out_valid = 0 in n+1.
  - The target instruction appears in n+2.
  - Entries fetched before the redirect never appear.
- Stall: instruction, pc and out_valid are held stable. Fetch continues until count + inflight = DEPTH, then mem_req = 0.
- Stall release at a full queue: the pop occurs at the next edge, mem_req rises the cycle after, and the new entry arrives two cycles later.
- PC wrap: after fetching 2^PC_WIDTH-1, the next address is 0.

## Test plan
- Reset, then free-run with memory[i] = i+100:
  - Out sequence is pc 0,1,2,… and instruction 100,101,…, one per cycle.
  - First out_valid 2 cycles after reset drops.
- Stall held 8 cycles at pc 3 (DEPTH=4):
  - pc stays 3 throughout.
  - count reaches 4 and mem_req goes low.
  - After release, pcs 3,4,5,6,7 appear with no gap or duplicate.
- is_jump to 0x40 while count = 3:
  - Next valid output is pc 0x40 two cycles later.
  - No entry between the old head and 0x40 is emitted.
- branch_taken to 0x10 and is_jump to 0x20 in the same cycle, under stall:
  - Flush occurs; the branch wins.
  - mem_addr = 0x10 in that cycle.
  - Next output is pc 0x10.
- rst pulsed while count = 2 with inflight set:
  - Outputs go to 0 immediately.
  - After release, fetch restarts at RESET_PC and the stale response is never queued.
- PC_WIDTH = 4, start by jump to 14:
  - Outputs are pc 14, 15, 0, 1.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: N-deep prefetch queue of {pc, instruction}
// pairs with redirect flush on branch/jump and hold under pipeline stall.
module if_fetch_queue #(
  parameter int PC_WIDTH   = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       branch_taken,
  input  logic [PC_WIDTH-1:0]        branch_addr,
  input  logic                       is_jump,
  input  logic [PC_WIDTH-1:0]        jump_addr,
  input  logic                       stall_pipeline,
  output logic                       mem_req,
  output logic [PC_WIDTH-1:0]        mem_addr,
  input  logic [INST_WIDTH-1:0]      mem_rdata,
  output logic                       out_valid,
  output logic [INST_WIDTH-1:0]      instruction,
  output logic [PC_WIDTH-1:0]        pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PC_WIDTH-1:0]   r_fetch_pc;
  logic [PC_WIDTH-1:0]   r_req_addr;
  logic                  r_inflight;
  logic                  r_drop;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [PC_WIDTH-1:0]   r_buf_pc   [DEPTH];
  logic [INST_WIDTH-1:0] r_buf_inst [DEPTH];

  logic                  w_redirect;
  logic [PC_WIDTH-1:0]   w_target;
  logic [CW:0]           w_occ;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_pop;

  // branch from EX is older than jump from ID, so it wins
  assign w_redirect = branch_taken | is_jump;
  assign w_target   = branch_taken ? branch_addr : jump_addr;

  // in-flight request reserves its slot so a write never overflows
  assign w_occ   = {1'b0, r_count} + (CW+1)'(r_inflight);
  assign w_issue = w_redirect | (w_occ < (CW+1)'(DEPTH));

  assign w_push = r_inflight & ~r_drop & ~w_redirect;
  assign w_pop  = out_valid & ~stall_pipeline & ~w_redirect;

  always_comb begin
    mem_req     = w_issue;
    mem_addr    = w_redirect ? w_target : r_fetch_pc;
    out_valid   = (r_count != '0);
    instruction = '0;
    pc          = '0;
    count       = r_count;
    if (out_valid) begin
      instruction = r_buf_inst[r_rd_ptr];
      pc          = r_buf_pc[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc <= mem_addr + PC_WIDTH'(1);
        r_req_addr <= mem_addr;
      end
      if (w_redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_drop   <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]   <= r_req_addr;
      r_buf_inst[r_wr_ptr] <= mem_rdata;
    end
  end

endmodule
